// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one AXI4-Lite master port between the IFU (read-only)
// and the LSU (read/write). One whole transaction is granted at a time and the
// grant is held until its response handshake completes.
//
// Ports:
//   clock, reset        - clock and asynchronous active-low reset
//   ifu_ar*/ifu_r*      - IFU read address / read data channels
//   lsu_ar*/lsu_r*      - LSU read address / read data channels
//   lsu_aw*/lsu_w*/lsu_b* - LSU write address / write data / write response
//   io_master_*         - downstream AXI4-Lite master port to the crossbar
module mem_bus_arbiter #(
    parameter bit          LSU_PRIORITY = 1'b1,
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  ifu_arvalid,
    output logic                  ifu_arready,
    input  logic [ADDR_W-1:0]     ifu_araddr,
    output logic                  ifu_rvalid,
    input  logic                  ifu_rready,
    output logic [DATA_W-1:0]     ifu_rdata,
    output logic [1:0]            ifu_rresp,

    input  logic                  lsu_arvalid,
    output logic                  lsu_arready,
    input  logic [ADDR_W-1:0]     lsu_araddr,
    output logic                  lsu_rvalid,
    input  logic                  lsu_rready,
    output logic [DATA_W-1:0]     lsu_rdata,
    output logic [1:0]            lsu_rresp,
    input  logic                  lsu_awvalid,
    output logic                  lsu_awready,
    input  logic [ADDR_W-1:0]     lsu_awaddr,
    input  logic                  lsu_wvalid,
    output logic                  lsu_wready,
    input  logic [DATA_W-1:0]     lsu_wdata,
    input  logic [DATA_W/8-1:0]   lsu_wstrb,
    output logic                  lsu_bvalid,
    input  logic                  lsu_bready,
    output logic [1:0]            lsu_bresp,

    output logic                  io_master_arvalid,
    input  logic                  io_master_arready,
    output logic [ADDR_W-1:0]     io_master_araddr,
    input  logic                  io_master_rvalid,
    output logic                  io_master_rready,
    input  logic [DATA_W-1:0]     io_master_rdata,
    input  logic [1:0]            io_master_rresp,
    output logic                  io_master_awvalid,
    input  logic                  io_master_awready,
    output logic [ADDR_W-1:0]     io_master_awaddr,
    output logic                  io_master_wvalid,
    input  logic                  io_master_wready,
    output logic [DATA_W-1:0]     io_master_wdata,
    output logic [DATA_W/8-1:0]   io_master_wstrb,
    input  logic                  io_master_bvalid,
    output logic                  io_master_bready,
    input  logic [1:0]            io_master_bresp
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam logic        RR_IFU = 1'b0;
    localparam logic        RR_LSU = 1'b1;

    typedef enum logic [1:0] {IDLE, IFU_RD, LSU_RD, LSU_WR} state_e;

    state_e state_q, state_d;
    logic   rr_last_q, rr_last_d;
    // Address/data handshake already done within the current grant; blocks a
    // second request from leaking out before the response returns.
    logic   ar_done_q, ar_done_d;
    logic   aw_done_q, aw_done_d;
    logic   w_done_q,  w_done_d;

    logic ifu_req, lsu_req;
    assign ifu_req = ifu_arvalid;
    assign lsu_req = lsu_arvalid | lsu_awvalid;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            rr_last_q <= RR_IFU;
            ar_done_q <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
            ar_done_q <= ar_done_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    // Arbitration (IDLE only) and grant release on the response handshake
    always_comb begin
        state_d   = state_q;
        rr_last_d = rr_last_q;
        ar_done_d = ar_done_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (state_q)
            IDLE: begin
                ar_done_d = 1'b0;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                // Round-robin: the LSU wins a conflict when the IFU had the last grant
                if (lsu_req && (LSU_PRIORITY || !ifu_req || rr_last_q == RR_IFU)) begin
                    state_d   = lsu_awvalid ? LSU_WR : LSU_RD;
                    rr_last_d = RR_LSU;
                end else if (ifu_req) begin
                    state_d   = IFU_RD;
                    rr_last_d = RR_IFU;
                end
            end
            IFU_RD, LSU_RD: begin
                if (io_master_arvalid && io_master_arready) ar_done_d = 1'b1;
                if (io_master_rvalid && io_master_rready)   state_d   = IDLE;
            end
            LSU_WR: begin
                if (io_master_awvalid && io_master_awready) aw_done_d = 1'b1;
                if (io_master_wvalid && io_master_wready)   w_done_d  = 1'b1;
                if (io_master_bvalid && io_master_bready)   state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Channel muxing for the granted requester; everything else reads as 0
    always_comb begin
        ifu_arready       = 1'b0;
        ifu_rvalid        = 1'b0;
        ifu_rdata         = '0;
        ifu_rresp         = 2'b00;
        lsu_arready       = 1'b0;
        lsu_rvalid        = 1'b0;
        lsu_rdata         = '0;
        lsu_rresp         = 2'b00;
        lsu_awready       = 1'b0;
        lsu_wready        = 1'b0;
        lsu_bvalid        = 1'b0;
        lsu_bresp         = 2'b00;
        io_master_arvalid = 1'b0;
        io_master_araddr  = '0;
        io_master_rready  = 1'b0;
        io_master_awvalid = 1'b0;
        io_master_awaddr  = '0;
        io_master_wvalid  = 1'b0;
        io_master_wdata   = '0;
        io_master_wstrb   = STRB_W'(0);
        io_master_bready  = 1'b0;
        case (state_q)
            IFU_RD: begin
                io_master_arvalid = ifu_arvalid & ~ar_done_q;
                io_master_araddr  = ifu_araddr;
                ifu_arready       = io_master_arready & ~ar_done_q;
                ifu_rvalid        = io_master_rvalid;
                ifu_rdata         = io_master_rdata;
                ifu_rresp         = io_master_rresp;
                io_master_rready  = ifu_rready;
            end
            LSU_RD: begin
                io_master_arvalid = lsu_arvalid & ~ar_done_q;
                io_master_araddr  = lsu_araddr;
                lsu_arready       = io_master_arready & ~ar_done_q;
                lsu_rvalid        = io_master_rvalid;
                lsu_rdata         = io_master_rdata;
                lsu_rresp         = io_master_rresp;
                io_master_rready  = lsu_rready;
            end
            LSU_WR: begin
                io_master_awvalid = lsu_awvalid & ~aw_done_q;
                io_master_awaddr  = lsu_awaddr;
                lsu_awready       = io_master_awready & ~aw_done_q;
                io_master_wvalid  = lsu_wvalid & ~w_done_q;
                io_master_wdata   = lsu_wdata;
                io_master_wstrb   = lsu_wstrb;
                lsu_wready        = io_master_wready & ~w_done_q;
                lsu_bvalid        = io_master_bvalid;
                lsu_bresp         = io_master_bresp;
                io_master_bready  = lsu_bready;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: instance 0 uses LSU priority, instance 1
// round-robin. A behavioural AXI4-Lite slave answers reads with
// addr ^ RD_KEY and flags addresses 0xE... with SLVERR.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;
    localparam logic [31:0] RD_KEY = 32'h8000_0413;
    localparam int BUDGET = 100;
    localparam int K_IFU = 0, K_LSUR = 1, K_LSUW = 2;

    typedef struct packed { logic [31:0] data; logic [1:0] resp; } exp_t;
    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          wdly;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic          ifu_arvalid [2], ifu_arready [2], ifu_rvalid [2], ifu_rready [2];
    logic [AW-1:0] ifu_araddr [2];
    logic [DW-1:0] ifu_rdata [2];
    logic [1:0]    ifu_rresp [2];
    logic          lsu_arvalid [2], lsu_arready [2], lsu_rvalid [2], lsu_rready [2];
    logic [AW-1:0] lsu_araddr [2], lsu_awaddr [2];
    logic [DW-1:0] lsu_rdata [2], lsu_wdata [2];
    logic [1:0]    lsu_rresp [2], lsu_bresp [2];
    logic          lsu_awvalid [2], lsu_awready [2], lsu_wvalid [2], lsu_wready [2];
    logic [SW-1:0] lsu_wstrb [2];
    logic          lsu_bvalid [2], lsu_bready [2];
    logic          m_arvalid [2], m_arready [2], m_rvalid [2], m_rready [2];
    logic [AW-1:0] m_araddr [2], m_awaddr [2];
    logic [DW-1:0] m_rdata [2], m_wdata [2];
    logic [1:0]    m_rresp [2], m_bresp [2];
    logic          m_awvalid [2], m_awready [2], m_wvalid [2], m_wready [2];
    logic [SW-1:0] m_wstrb [2];
    logic          m_bvalid [2], m_bready [2];

    for (genvar d = 0; d < 2; d++) begin : g_dut
        mem_bus_arbiter #(.LSU_PRIORITY(d == 0 ? 1'b1 : 1'b0), .ADDR_W(AW), .DATA_W(DW)) u_dut (
            .clock(clock), .reset(reset),
            .ifu_arvalid(ifu_arvalid[d]), .ifu_arready(ifu_arready[d]), .ifu_araddr(ifu_araddr[d]),
            .ifu_rvalid(ifu_rvalid[d]), .ifu_rready(ifu_rready[d]), .ifu_rdata(ifu_rdata[d]),
            .ifu_rresp(ifu_rresp[d]),
            .lsu_arvalid(lsu_arvalid[d]), .lsu_arready(lsu_arready[d]), .lsu_araddr(lsu_araddr[d]),
            .lsu_rvalid(lsu_rvalid[d]), .lsu_rready(lsu_rready[d]), .lsu_rdata(lsu_rdata[d]),
            .lsu_rresp(lsu_rresp[d]),
            .lsu_awvalid(lsu_awvalid[d]), .lsu_awready(lsu_awready[d]), .lsu_awaddr(lsu_awaddr[d]),
            .lsu_wvalid(lsu_wvalid[d]), .lsu_wready(lsu_wready[d]), .lsu_wdata(lsu_wdata[d]),
            .lsu_wstrb(lsu_wstrb[d]),
            .lsu_bvalid(lsu_bvalid[d]), .lsu_bready(lsu_bready[d]), .lsu_bresp(lsu_bresp[d]),
            .io_master_arvalid(m_arvalid[d]), .io_master_arready(m_arready[d]),
            .io_master_araddr(m_araddr[d]),
            .io_master_rvalid(m_rvalid[d]), .io_master_rready(m_rready[d]),
            .io_master_rdata(m_rdata[d]), .io_master_rresp(m_rresp[d]),
            .io_master_awvalid(m_awvalid[d]), .io_master_awready(m_awready[d]),
            .io_master_awaddr(m_awaddr[d]),
            .io_master_wvalid(m_wvalid[d]), .io_master_wready(m_wready[d]),
            .io_master_wdata(m_wdata[d]), .io_master_wstrb(m_wstrb[d]),
            .io_master_bvalid(m_bvalid[d]), .io_master_bready(m_bready[d]),
            .io_master_bresp(m_bresp[d])
        );
    end

    // Behavioural slaves, one per instance
    logic          s_rbusy [2], s_rvalid [2], s_awgot [2], s_wgot [2], s_bvalid [2];
    logic [1:0]    s_rcnt [2];
    logic [AW-1:0] s_raddr [2], s_awaddr [2];
    logic          aw_stall;

    always_comb begin
        for (int d = 0; d < 2; d++) begin
            m_arready[d] = !s_rbusy[d];
            m_rvalid[d]  = s_rvalid[d];
            m_rdata[d]   = s_rvalid[d] ? (s_raddr[d] ^ RD_KEY) : 32'h0;
            m_rresp[d]   = (s_rvalid[d] && s_raddr[d][31:28] == 4'hE) ? 2'b10 : 2'b00;
            m_awready[d] = !s_awgot[d] && !aw_stall;
            m_wready[d]  = !s_wgot[d];
            m_bvalid[d]  = s_bvalid[d];
            m_bresp[d]   = (s_bvalid[d] && s_awaddr[d][31:28] == 4'hE) ? 2'b10 : 2'b00;
        end
    end

    always @(posedge clock or negedge reset) begin
        for (int d = 0; d < 2; d++) begin
            if (!reset) begin
                s_rbusy[d] <= 1'b0; s_rvalid[d] <= 1'b0; s_rcnt[d] <= 2'd0; s_raddr[d] <= '0;
                s_awgot[d] <= 1'b0; s_wgot[d] <= 1'b0; s_bvalid[d] <= 1'b0; s_awaddr[d] <= '0;
            end else begin
                if (m_arvalid[d] && !s_rbusy[d]) begin
                    s_rbusy[d] <= 1'b1; s_raddr[d] <= m_araddr[d]; s_rcnt[d] <= 2'd1;
                end else if (s_rbusy[d] && !s_rvalid[d]) begin
                    if (s_rcnt[d] == 2'd0) s_rvalid[d] <= 1'b1;
                    else s_rcnt[d] <= s_rcnt[d] - 2'd1;
                end else if (s_rvalid[d] && m_rready[d]) begin
                    s_rvalid[d] <= 1'b0; s_rbusy[d] <= 1'b0;
                end
                if (m_awvalid[d] && m_awready[d]) begin
                    s_awgot[d] <= 1'b1; s_awaddr[d] <= m_awaddr[d];
                end
                if (m_wvalid[d] && m_wready[d]) s_wgot[d] <= 1'b1;
                if (s_awgot[d] && s_wgot[d] && !s_bvalid[d]) s_bvalid[d] <= 1'b1;
                if (s_bvalid[d] && m_bready[d]) begin
                    s_bvalid[d] <= 1'b0; s_awgot[d] <= 1'b0; s_wgot[d] <= 1'b0;
                end
            end
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    exp_t q_ifu[$], q_lsur[$], q_lsub[$];
    logic [31:0] glog[$];
    int          gcyc[$];
    int          lsu_r_cyc, b_high;
    logic        lsu_seen;
    logic [31:0] cap_awaddr, cap_wdata;
    logic [3:0]  cap_wstrb;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s", name);
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Response scoreboard and grant logger
    always @(negedge clock) begin
        if (reset) begin
            for (int d = 0; d < 2; d++) begin
                exp_t e;
                if (ifu_rvalid[d] && ifu_rready[d]) begin
                    if (q_ifu.size() == 0) fail_now("ifu_r unexpected response");
                    else begin
                        e = q_ifu.pop_front();
                        check("ifu_rdata", 64'(ifu_rdata[d]), 64'(e.data));
                        check("ifu_rresp", 64'(ifu_rresp[d]), 64'(e.resp));
                    end
                end
                if (lsu_rvalid[d] && lsu_rready[d]) begin
                    lsu_r_cyc = cyc;
                    if (q_lsur.size() == 0) fail_now("lsu_r unexpected response");
                    else begin
                        e = q_lsur.pop_front();
                        check("lsu_rdata", 64'(lsu_rdata[d]), 64'(e.data));
                        check("lsu_rresp", 64'(lsu_rresp[d]), 64'(e.resp));
                    end
                end
                if (lsu_bvalid[d]) b_high++;
                if (lsu_bvalid[d] && lsu_bready[d]) begin
                    if (q_lsub.size() == 0) fail_now("lsu_b unexpected response");
                    else begin
                        e = q_lsub.pop_front();
                        check("lsu_bresp", 64'(lsu_bresp[d]), 64'(e.resp));
                    end
                end
                if (m_arvalid[d] && m_arready[d]) begin
                    glog.push_back(m_araddr[d]); gcyc.push_back(cyc);
                end
                if (m_awvalid[d] && m_awready[d]) begin
                    glog.push_back(m_awaddr[d]); gcyc.push_back(cyc); cap_awaddr = m_awaddr[d];
                end
                if (m_wvalid[d] && m_wready[d]) begin
                    cap_wdata = m_wdata[d]; cap_wstrb = m_wstrb[d];
                end
                if (lsu_arready[d] || lsu_rvalid[d] || lsu_awready[d] || lsu_wready[d] || lsu_bvalid[d])
                    lsu_seen = 1'b1;
            end
        end
    end

    task automatic ifu_read(input int d, input logic [31:0] addr, input logic [31:0] ed, input logic [1:0] er);
        int t;
        q_ifu.push_back('{ed, er});
        ifu_araddr[d] = addr; ifu_arvalid[d] = 1'b1;
        t = 0; @(negedge clock);
        while (!ifu_arready[d] && t < BUDGET) begin t++; @(negedge clock); end
        if (t >= BUDGET) fail_now("ifu_ar timeout");
        @(posedge clock); #1;
        ifu_arvalid[d] = 1'b0; ifu_araddr[d] = '0; ifu_rready[d] = 1'b1;
        t = 0; @(negedge clock);
        while (!ifu_rvalid[d] && t < BUDGET) begin t++; @(negedge clock); end
        if (t >= BUDGET) fail_now("ifu_r timeout");
        @(posedge clock); #1;
        ifu_rready[d] = 1'b0;
    endtask

    task automatic lsu_read(input int d, input logic [31:0] addr, input logic [31:0] ed, input logic [1:0] er);
        int t;
        q_lsur.push_back('{ed, er});
        lsu_araddr[d] = addr; lsu_arvalid[d] = 1'b1;
        t = 0; @(negedge clock);
        while (!lsu_arready[d] && t < BUDGET) begin t++; @(negedge clock); end
        if (t >= BUDGET) fail_now("lsu_ar timeout");
        @(posedge clock); #1;
        lsu_arvalid[d] = 1'b0; lsu_araddr[d] = '0; lsu_rready[d] = 1'b1;
        t = 0; @(negedge clock);
        while (!lsu_rvalid[d] && t < BUDGET) begin t++; @(negedge clock); end
        if (t >= BUDGET) fail_now("lsu_r timeout");
        @(posedge clock); #1;
        lsu_rready[d] = 1'b0;
    endtask

    task automatic lsu_write(input int d, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int wdly, input logic [1:0] er);
        int t;
        q_lsub.push_back('{32'h0, er});
        lsu_awaddr[d] = addr; lsu_awvalid[d] = 1'b1;
        t = 0; @(negedge clock);
        while (!lsu_awready[d] && t < BUDGET) begin t++; @(negedge clock); end
        if (t >= BUDGET) fail_now("lsu_aw timeout");
        @(posedge clock); #1;
        lsu_awvalid[d] = 1'b0; lsu_awaddr[d] = '0;
        repeat (wdly - 1) @(posedge clock);
        #1;
        lsu_wdata[d] = data; lsu_wstrb[d] = strb; lsu_wvalid[d] = 1'b1;
        t = 0; @(negedge clock);
        while (!lsu_wready[d] && t < BUDGET) begin t++; @(negedge clock); end
        if (t >= BUDGET) fail_now("lsu_w timeout");
        @(posedge clock); #1;
        lsu_wvalid[d] = 1'b0; lsu_wdata[d] = '0; lsu_wstrb[d] = '0; lsu_bready[d] = 1'b1;
        t = 0; @(negedge clock);
        while (!lsu_bvalid[d] && t < BUDGET) begin t++; @(negedge clock); end
        if (t >= BUDGET) fail_now("lsu_b timeout");
        @(posedge clock); #1;
        lsu_bready[d] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1);
    end

    initial begin
        vec_t vecs [7];
        int   b0;
        vecs[0] = '{K_IFU,  32'h8000_0000, 32'h0,         4'h0, 1, 32'h0000_0413, 2'b00};
        vecs[1] = '{K_LSUR, 32'h8000_1000, 32'h0,         4'h0, 1, 32'h0000_1413, 2'b00};
        vecs[2] = '{K_LSUW, 32'hA000_03F8, 32'h0000_0041, 4'h1, 3, 32'h0,         2'b00};
        vecs[3] = '{K_LSUR, 32'hE000_0010, 32'h0,         4'h0, 1, 32'h6000_0403, 2'b10};
        vecs[4] = '{K_IFU,  32'h1234_5678, 32'h0,         4'h0, 1, 32'h9234_526B, 2'b00};
        vecs[5] = '{K_LSUW, 32'hE000_0000, 32'hDEAD_BEEF, 4'hF, 1, 32'h0,         2'b10};
        vecs[6] = '{K_IFU,  32'hE000_0100, 32'h0,         4'h0, 1, 32'h6000_0513, 2'b10};

        aw_stall = 1'b0; lsu_seen = 1'b0; b_high = 0; lsu_r_cyc = 0;
        cap_awaddr = '0; cap_wdata = '0; cap_wstrb = '0;
        for (int d = 0; d < 2; d++) begin
            ifu_arvalid[d] = 1'b0; ifu_araddr[d] = '0; ifu_rready[d] = 1'b0;
            lsu_arvalid[d] = 1'b0; lsu_araddr[d] = '0; lsu_rready[d] = 1'b0;
            lsu_awvalid[d] = 1'b0; lsu_awaddr[d] = '0; lsu_wvalid[d] = 1'b0;
            lsu_wdata[d] = '0; lsu_wstrb[d] = '0; lsu_bready[d] = 1'b0;
        end

        // Reset: outputs stay 0 even with requests and ready inputs active
        reset = 1'b0;
        ifu_arvalid[0] = 1'b1; ifu_araddr[0] = 32'h1111_1111;
        lsu_awvalid[0] = 1'b1; lsu_awaddr[0] = 32'h2222_2222;
        lsu_wvalid[0] = 1'b1; lsu_wdata[0] = 32'h3333_3333; lsu_wstrb[0] = 4'hF;
        lsu_rready[0] = 1'b1; lsu_bready[0] = 1'b1; ifu_rready[0] = 1'b1;
        #22;
        check("reset valid/ready", 64'({ifu_arready[0], ifu_rvalid[0], lsu_arready[0], lsu_rvalid[0],
              lsu_awready[0], lsu_wready[0], lsu_bvalid[0], m_arvalid[0], m_rready[0],
              m_awvalid[0], m_wvalid[0], m_bready[0]}), 64'h0);
        check("reset io_master addr", {m_araddr[0], m_awaddr[0]}, 64'h0);
        check("reset io_master wdata/wstrb", 64'({m_wdata[0], m_wstrb[0]}), 64'h0);
        check("reset rdata", {ifu_rdata[0], lsu_rdata[0]}, 64'h0);
        check("reset resp", 64'({ifu_rresp[0], lsu_rresp[0], lsu_bresp[0]}), 64'h0);
        ifu_arvalid[0] = 1'b0; ifu_araddr[0] = '0; lsu_awvalid[0] = 1'b0; lsu_awaddr[0] = '0;
        lsu_wvalid[0] = 1'b0; lsu_wdata[0] = '0; lsu_wstrb[0] = '0;
        lsu_rready[0] = 1'b0; lsu_bready[0] = 1'b0; ifu_rready[0] = 1'b0;
        @(negedge clock); reset = 1'b1;
        @(posedge clock); #1;

        // Table of single transactions on the LSU-priority instance
        for (int i = 0; i < 7; i++) begin
            lsu_seen = 1'b0;
            b0 = b_high;
            case (vecs[i].kind)
                K_IFU:  ifu_read(0, vecs[i].addr, vecs[i].exp_data, vecs[i].exp_resp);
                K_LSUR: lsu_read(0, vecs[i].addr, vecs[i].exp_data, vecs[i].exp_resp);
                default: lsu_write(0, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb,
                                   vecs[i].wdly, vecs[i].exp_resp);
            endcase
            if (vecs[i].kind == K_IFU) check("ifu-only lsu quiet", 64'(lsu_seen), 64'h0);
            if (vecs[i].kind == K_LSUW) begin
                check("io_master_awaddr", 64'(cap_awaddr), 64'(vecs[i].addr));
                check("io_master_wdata", 64'(cap_wdata), 64'(vecs[i].wdata));
                check("io_master_wstrb", 64'(cap_wstrb), 64'(vecs[i].wstrb));
                check("lsu_bvalid pulses", 64'(b_high - b0), 64'h1);
            end
            @(negedge clock);
            check("idle after txn", 64'({m_arvalid[0], m_awvalid[0], m_wvalid[0], m_rready[0], m_bready[0]}), 64'h0);
            @(posedge clock); #1;
        end

        // Simultaneous IFU + LSU read with LSU priority
        glog.delete(); gcyc.delete();
        fork
            ifu_read(0, 32'h8000_0000, 32'h0000_0413, 2'b00);
            lsu_read(0, 32'h8000_1000, 32'h0000_1413, 2'b00);
        join
        if (glog.size() != 2) fail_now("priority grant count");
        else begin
            check("priority first grant", 64'(glog[0]), 64'h8000_1000);
            check("priority second grant", 64'(glog[1]), 64'h8000_0000);
            check("ifu ar after lsu r", 64'(gcyc[1] - lsu_r_cyc), 64'd2);
        end

        // Error response on LSU read releases the grant to a waiting IFU
        glog.delete(); gcyc.delete();
        fork
            lsu_read(0, 32'hE000_0020, 32'h6000_0433, 2'b10);
            ifu_read(0, 32'h8000_0008, 32'h0000_041B, 2'b00);
        join
        if (glog.size() != 2) fail_now("error grant count");
        else begin
            check("error first grant", 64'(glog[0]), 64'hE000_0020);
            check("error then ifu", 64'(glog[1]), 64'h8000_0008);
        end

        // Round-robin: both requesting back-to-back
        glog.delete(); gcyc.delete();
        fork
            begin
                lsu_read(1, 32'h8000_1000, 32'h0000_1413, 2'b00);
                lsu_read(1, 32'h8000_1004, 32'h0000_1417, 2'b00);
            end
            begin
                ifu_read(1, 32'h8000_0000, 32'h0000_0413, 2'b00);
                ifu_read(1, 32'h8000_0004, 32'h0000_0417, 2'b00);
            end
        join
        if (glog.size() != 4) fail_now("rr grant count");
        else begin
            check("rr grant 0", 64'(glog[0]), 64'h8000_1000);
            check("rr grant 1", 64'(glog[1]), 64'h8000_0000);
            check("rr grant 2", 64'(glog[2]), 64'h8000_1004);
            check("rr grant 3", 64'(glog[3]), 64'h8000_0004);
        end

        // Async reset while a write address is stalled
        aw_stall = 1'b1;
        lsu_awaddr[0] = 32'hA000_0000; lsu_awvalid[0] = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("awvalid while granted", 64'(m_awvalid[0]), 64'h1);
        #2 reset = 1'b0;
        #1;
        check("awvalid after async reset", 64'(m_awvalid[0]), 64'h0);
        check("awready after async reset", 64'(lsu_awready[0]), 64'h0);
        lsu_awvalid[0] = 1'b0; lsu_awaddr[0] = '0; aw_stall = 1'b0;
        @(negedge clock); reset = 1'b1;
        @(posedge clock); #1;
        ifu_read(0, 32'h8000_0040, 32'h0000_0453, 2'b00);

        repeat (3) @(posedge clock);
        check("ifu queue drained", 64'(q_ifu.size()), 64'h0);
        check("lsu r queue drained", 64'(q_lsur.size()), 64'h0);
        check("lsu b queue drained", 64'(q_lsub.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
